// File: rtl/mul_share_ctrl_if.sv
// Bundle between the shared-multiplier controller, its two requesters and
// the multiplier it drives.
//
// Handshake: reqX is a level request, held with stable aX/bX until the
// cycle in which doneX=1 is visible. It must be low on the clock edge that
// samples doneX=1. doneX is a one-cycle pulse. result/err are valid with
// doneX, and result holds until the next done pulse. The multiplier side
// has no ready: mul_valid is sampled only while an operation is waiting.
interface mul_share_ctrl_if #(
    parameter int WIDTH = 16
);
    logic                   req0;
    logic [WIDTH-1:0]       a0;
    logic [WIDTH-1:0]       b0;
    logic                   req1;
    logic [WIDTH-1:0]       a1;
    logic [WIDTH-1:0]       b1;
    logic                   done0;
    logic                   done1;
    logic [2*WIDTH-1:0]     result;
    logic                   err;
    logic                   busy;
    logic [3:0]             mul_control;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic [2*WIDTH-1:0]     mul_r;
    logic                   mul_valid;

    // Environment side: requesters plus the multiplier itself
    modport master (
        output req0, a0, b0, req1, a1, b1, mul_r, mul_valid,
        input  done0, done1, result, err, busy, mul_control, mul_a, mul_b
    );

    // Controller side
    modport slave (
        input  req0, a0, b0, req1, a1, b1, mul_r, mul_valid,
        output done0, done1, result, err, busy, mul_control, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Shares one multi-cycle multiplier between two requesters with round-robin
// arbitration, a stale-validity guard cycle and a watchdog timeout.
module mul_share_ctrl #(
    parameter int         WIDTH    = 16,
    parameter logic [3:0] CTRL_MUL = 4'b1000,
    parameter logic [3:0] CTRL_NOP = 4'b0000,
    parameter int         TIMEOUT  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_share_ctrl_if.slave      bus,
    output logic [1:0]           dbg_state
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 last_gnt_q, last_gnt_d;
    logic                 gnt_q, gnt_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic [3:0]           mul_control_q, mul_control_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 win;
    logic                 finish;

    // Next-state and registered-output logic for the arbitration FSM
    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        gnt_d         = gnt_q;
        wcnt_d        = wcnt_q;
        mul_control_d = mul_control_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        result_d      = result_q;
        err_d         = err_q;
        busy_d        = busy_q;
        win           = 1'b0;
        finish        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    // Tie goes to the port that did not win last time
                    win           = (bus.req0 & bus.req1) ? ~last_gnt_q : bus.req1;
                    gnt_d         = win;
                    last_gnt_d    = win;
                    mul_a_d       = win ? bus.a1 : bus.a0;
                    mul_b_d       = win ? bus.b1 : bus.b0;
                    mul_control_d = CTRL_MUL;
                    wcnt_d        = '0;
                    busy_d        = 1'b1;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                // The first wait cycle may still see validity left over from
                // the previous operation, so it is never accepted there.
                if ((wcnt_q != '0) && bus.mul_valid) begin
                    result_d = bus.mul_r;
                    err_d    = 1'b0;
                    finish   = 1'b1;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    finish   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
                if (finish) begin
                    done0_d       = ~gnt_q;
                    done1_d       = gnt_q;
                    mul_control_d = CTRL_NOP;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_gnt_q    <= 1'b1;
            gnt_q         <= 1'b0;
            wcnt_q        <= '0;
            mul_control_q <= CTRL_NOP;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            result_q      <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_gnt_q    <= last_gnt_d;
            gnt_q         <= gnt_d;
            wcnt_q        <= wcnt_d;
            mul_control_q <= mul_control_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            result_q      <= result_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.result      = result_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.mul_control = mul_control_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: behavioural multiplier, directed scenarios and
// randomized request rounds checked against a queue-based reference.
module tb_mul_share_ctrl;
    localparam int         W     = 16;
    localparam int         TO    = 32;
    localparam logic [3:0] C_MUL = 4'b1000;
    localparam logic [3:0] C_NOP = 4'b0000;

    typedef struct {
        bit             port;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] r;
        bit             e;
    } op_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    mul_share_ctrl_if #(.WIDTH(W)) bus ();

    mul_share_ctrl #(
        .WIDTH(W), .CTRL_MUL(C_MUL), .CTRL_NOP(C_NOP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- multiplier model ----------------
    int             m_lat   = 4;
    bit             m_stale = 1'b0;
    bit             m_hang  = 1'b0;
    int             m_cnt;
    logic           m_valid;
    logic [2*W-1:0] m_r;

    // Product appears m_lat cycles after control goes to MUL; validity is
    // dropped on the first MUL cycle, and optionally kept high while idle.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_r     <= '0;
        end else if (bus.mul_control == C_MUL) begin
            m_cnt <= m_cnt + 1;
            if (!m_hang && (m_cnt + 1 == m_lat)) begin
                m_valid <= 1'b1;
                m_r     <= {{W{1'b0}}, bus.mul_a} * {{W{1'b0}}, bus.mul_b};
            end else if (m_cnt == 0) begin
                m_valid <= 1'b0;
            end
        end else begin
            m_cnt <= 0;
            if (!m_stale) m_valid <= 1'b0;
        end
    end

    assign bus.mul_r     = m_r;
    assign bus.mul_valid = m_valid;

    // ---------------- scoreboard ----------------
    op_t            exp_q[$];
    int             total = 0;
    int             bad   = 0;
    bit             last_gnt;
    logic [2*W-1:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic op_t mk_op(input bit p, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit hang);
        op_t o;
        o.port = p;
        o.a    = a;
        o.b    = b;
        o.r    = hang ? '0 : ({{W{1'b0}}, a} * {{W{1'b0}}, b});
        o.e    = hang;
        return o;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_done0"}, bus.done0, 0);
        check({tag, "_done1"}, bus.done1, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_ctrl"}, bus.mul_control, C_NOP);
        check({tag, "_mul_a"}, bus.mul_a, 0);
        check({tag, "_mul_b"}, bus.mul_b, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- driver ----------------
    task automatic run_round(input bit r0, input bit r1,
                             input logic [W-1:0] x0, input logic [W-1:0] y0,
                             input logic [W-1:0] x1, input logic [W-1:0] y1,
                             input int lat, input bit stale, input bit hang);
        int  k;
        int  exp_lat;
        bit  first_seen;
        bit  w;
        op_t cur;
        @(negedge clk);
        m_lat   = lat;
        m_stale = stale;
        m_hang  = hang;
        bus.a0  = x0;
        bus.b0  = y0;
        bus.a1  = x1;
        bus.b1  = y1;
        bus.req0 = r0;
        bus.req1 = r1;
        if (r0 && r1) begin
            w = ~last_gnt;
            exp_q.push_back(mk_op(w, w ? x1 : x0, w ? y1 : y0, hang));
            exp_q.push_back(mk_op(~w, w ? x0 : x1, w ? y0 : y1, hang));
            last_gnt = ~w;
        end else if (r0) begin
            exp_q.push_back(mk_op(1'b0, x0, y0, hang));
            last_gnt = 1'b0;
        end else if (r1) begin
            exp_q.push_back(mk_op(1'b1, x1, y1, hang));
            last_gnt = 1'b1;
        end
        exp_lat    = (hang || lat >= TO) ? TO + 1 : lat + 2;
        first_seen = 1'b0;
        k          = 0;
        while (exp_q.size() > 0 && k < 300) begin
            @(negedge clk);
            k++;
            cur = exp_q[0];
            if (bus.done0 || bus.done1) begin
                check("done_port", bus.done1, cur.port);
                check("done_both", bus.done0 & bus.done1, 0);
                check("result", bus.result, cur.r);
                check("err", bus.err, cur.e);
                check("busy_done", bus.busy, 1);
                check("ctrl_done", bus.mul_control, C_NOP);
                if (!first_seen && !(r0 && r1)) check("latency", k, exp_lat);
                first_seen = 1'b1;
                held = cur.r;
                if (cur.port) bus.req1 = 1'b0;
                else          bus.req0 = 1'b0;
                void'(exp_q.pop_front());
            end else begin
                check("result_held", bus.result, held);
                if (bus.mul_control == C_MUL) begin
                    check("mul_a_stable", bus.mul_a, cur.a);
                    check("mul_b_stable", bus.mul_b, cur.b);
                    check("busy_wait", bus.busy, 1);
                    // Operands of the granted port no longer matter
                    if (cur.port) begin
                        bus.a1 = W'($urandom);
                        bus.b1 = W'($urandom);
                    end else begin
                        bus.a0 = W'($urandom);
                        bus.b0 = W'($urandom);
                    end
                end
            end
        end
        check("round_budget", exp_q.size(), 0);
        exp_q.delete();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        check("busy_idle", bus.busy, 0);
        check("ctrl_idle", bus.mul_control, C_NOP);
        check("no_done_idle", bus.done0 | bus.done1, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sel;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.a1   = '0;
        bus.b1   = '0;
        last_gnt = 1'b1;
        held     = '0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;

        // T1: single request on port 0
        run_round(1'b1, 1'b0, 16'd21845, 16'd1, 16'd0, 16'd0, 4, 1'b0, 1'b0);

        // T2: simultaneous first requests after reset, port 0 wins the tie
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_gnt = 1'b1;
        held = '0;
        check_reset_values("rst2");
        run_round(1'b1, 1'b1, 16'd1, 16'd21845, 16'd10922, 16'd2, 3, 1'b0, 1'b0);

        // T3: both held for six operations, alternating grants
        for (int i = 0; i < 3; i++)
            run_round(1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                      $urandom_range(1, 6), 1'b0, 1'b0);

        // T4: stale validity left high from the previous operation
        run_round(1'b1, 1'b0, 16'd3, 16'd4, 16'd0, 16'd0, 3, 1'b1, 1'b0);
        run_round(1'b1, 1'b0, 16'hFFFF, 16'd21845, 16'd0, 16'd0, 3, 1'b1, 1'b0);
        run_round(1'b0, 1'b1, 16'd0, 16'd0, 16'd77, 16'd99, 1, 1'b1, 1'b0);

        // T5: multiplier never answers, then a normal operation
        run_round(1'b0, 1'b1, 16'd0, 16'd0, 16'd1234, 16'd567, 4, 1'b0, 1'b1);
        run_round(1'b0, 1'b1, 16'd0, 16'd0, 16'd321, 16'd123, 2, 1'b0, 1'b0);

        // Validity arriving on the last permitted wait cycle still wins
        run_round(1'b1, 1'b0, 16'd999, 16'd1001, 16'd0, 16'd0, TO - 1, 1'b0, 1'b0);

        // T6: reset in the middle of a wait
        @(negedge clk);
        m_lat    = 8;
        m_stale  = 1'b0;
        m_hang   = 1'b0;
        bus.a1   = 16'd7;
        bus.b1   = 16'd9;
        bus.req1 = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", bus.busy, 1);
        rst      = 1'b1;
        bus.req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_mid");
        last_gnt = 1'b1;
        held = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_rst", bus.done0 | bus.done1, 0);
        end
        run_round(1'b0, 1'b1, 16'd0, 16'd0, 16'd3, 16'd5, 3, 1'b0, 1'b0);

        // Randomized rounds
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(1, 3);
            run_round(sel[0], sel[1], W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                      $urandom_range(1, 8), bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit
    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
